// File: rtl/corelet_pkg.sv
// Shared constants and state encoding for the corelet output-drain path.
package corelet_pkg;

    localparam int COL_DEF     = 8;
    localparam int PSUM_BW_DEF = 16;
    localparam int DEPTH_DEF   = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FLUSH = 2'd2
    } drain_state_t;

endpackage

// File: rtl/ofifo_drain_psum_rf.sv
// Partial-sum accumulation buffer: one synchronous write port, one asynchronous read port.
module psum_rf
    import corelet_pkg::*;
#(
    parameter  int depth   = DEPTH_DEF,
    parameter  int width   = COL_DEF * PSUM_BW_DEF,
    localparam int addr_bw = $clog2(depth)
) (
    input  logic               clk,
    input  logic               we,
    input  logic [addr_bw-1:0] waddr,
    input  logic [width-1:0]   wdata,
    input  logic [addr_bw-1:0] raddr,
    output logic [width-1:0]   rdata
);

    // Contents are intentionally not reset; the first pass overwrites them.
    logic [width-1:0] mem [depth];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ofifo_drain.sv
// Drains OFIFO vectors into the psum buffer, accumulating across passes and emitting ReLU results on the last pass.
module ofifo_drain
    import corelet_pkg::*;
#(
    parameter  int col     = COL_DEF,
    parameter  int psum_bw = PSUM_BW_DEF,
    parameter  int depth   = DEPTH_DEF,
    localparam int addr_bw = $clog2(depth)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [addr_bw:0]         len,
    input  logic                     first_pass,
    input  logic                     last_pass,
    input  logic                     ofifo_valid,
    input  logic [col*psum_bw-1:0]   ofifo_output,
    output logic                     ofifo_rd,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [col*psum_bw-1:0]   out_data,
    output logic [addr_bw-1:0]       out_addr,
    output logic                     busy,
    output logic                     done
);

    localparam logic [addr_bw:0]   CNT_ONE  = {{addr_bw{1'b0}}, 1'b1};
    localparam logic [addr_bw-1:0] ADDR_ONE = {{(addr_bw-1){1'b0}}, 1'b1};

    drain_state_t state, state_nxt;

    logic [addr_bw:0]       len_q;
    logic [addr_bw:0]       rd_cnt;
    logic [addr_bw-1:0]     wr_addr;
    logic                   first_q, last_q;
    logic                   inflight;
    logic                   rd_en;
    logic                   accept;
    logic [col*psum_bw-1:0] rf_rdata;
    logic [col*psum_bw-1:0] acc_vec;
    logic [col*psum_bw-1:0] relu_vec;
    logic [col*psum_bw-1:0] wr_vec;

    logic signed [psum_bw-1:0] lane_in, lane_old, lane_sum;

    assign accept = out_valid && out_ready;
    assign busy   = (state != ST_IDLE);

    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = (len == '0) ? ST_FLUSH : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // A read is only launched when the result slot is guaranteed free on arrival.
                rd_en = ofifo_valid && (rd_cnt < len_q) && !inflight
                        && (!out_valid || out_ready);
                if ((rd_cnt == len_q) && !inflight) begin
                    state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (!out_valid || out_ready) begin
                    done      = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (reset) begin
            rd_en = 1'b0;
            done  = 1'b0;
        end
    end

    assign ofifo_rd = rd_en;

    always_comb begin
        acc_vec  = '0;
        relu_vec = '0;
        lane_in  = '0;
        lane_old = '0;
        lane_sum = '0;
        for (int unsigned k = 0; k < col; k++) begin
            lane_in  = ofifo_output[k*psum_bw +: psum_bw];
            lane_old = rf_rdata[k*psum_bw +: psum_bw];
            lane_sum = first_q ? lane_in : lane_old + lane_in;
            acc_vec[k*psum_bw +: psum_bw]  = lane_sum;
            relu_vec[k*psum_bw +: psum_bw] = lane_sum[psum_bw-1] ? '0 : lane_sum;
        end
    end

    assign wr_vec = last_q ? relu_vec : acc_vec;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            len_q     <= '0;
            first_q   <= 1'b0;
            last_q    <= 1'b0;
            rd_cnt    <= '0;
            wr_addr   <= '0;
            inflight  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_addr  <= '0;
        end else begin
            state <= state_nxt;
            if ((state == ST_IDLE) && start) begin
                len_q   <= len;
                first_q <= first_pass;
                last_q  <= last_pass;
                rd_cnt  <= '0;
                wr_addr <= '0;
            end
            if (rd_en) begin
                rd_cnt <= rd_cnt + CNT_ONE;
            end
            inflight <= rd_en;
            if (inflight) begin
                wr_addr <= wr_addr + ADDR_ONE;
            end
            if (inflight && last_q) begin
                out_valid <= 1'b1;
                out_data  <= relu_vec;
                out_addr  <= wr_addr;
            end else if (accept) begin
                out_valid <= 1'b0;
            end
        end
    end

    psum_rf #(
        .depth (depth),
        .width (col * psum_bw)
    ) u_rf (
        .clk   (clk),
        .we    (inflight),
        .waddr (wr_addr),
        .wdata (wr_vec),
        .raddr (wr_addr),
        .rdata (rf_rdata)
    );

endmodule

// File: tb/tb_ofifo_drain.sv
// Scoreboard bench for ofifo_drain: directed passes, expected results queued, monitor pops on each accepted output.
module tb_ofifo_drain;

    logic         clk;
    logic         reset;
    logic         start;
    logic [4:0]   len;
    logic         first_pass;
    logic         last_pass;
    logic         ofifo_valid;
    logic [127:0] ofifo_output;
    logic         ofifo_rd;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic [3:0]   out_addr;
    logic         busy;
    logic         done;

    ofifo_drain #(
        .col     (8),
        .psum_bw (16),
        .depth   (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .len          (len),
        .first_pass   (first_pass),
        .last_pass    (last_pass),
        .ofifo_valid  (ofifo_valid),
        .ofifo_output (ofifo_output),
        .ofifo_rd     (ofifo_rd),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_addr     (out_addr),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   addr;
        logic [127:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int total = 0;
    int bad   = 0;
    int rd_pulses = 0;
    int done_cnt  = 0;
    int ov_cnt    = 0;
    int r0, d0, o0;

    // OFIFO model: vectors preloaded by stimulus, one-cycle read latency.
    logic [127:0] vec_mem [0:63];
    int  nvec = 0;
    int  rptr = 0;
    logic fifo_en;
    logic fifo_clr;

    assign ofifo_valid = fifo_en && (rptr < nvec);

    always @(posedge clk) begin
        if (fifo_clr) begin
            rptr <= nvec;
        end else if (ofifo_rd) begin
            ofifo_output <= vec_mem[rptr];
            rptr         <= rptr + 1;
        end
    end

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (done) done_cnt++;
            if (out_valid) ov_cnt++;
            if (ofifo_rd) begin
                rd_pulses++;
                check("rd_only_when_valid", ofifo_valid, 1);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out: got addr %0d data %0h want no output", out_addr, out_data);
                end else begin
                    mon_e = sb.pop_front();
                    check("out_addr", out_addr, mon_e.addr);
                    check("out_data", out_data, mon_e.data);
                end
            end
        end
    end

    function automatic logic [127:0] mk(input int base, input int step);
        logic [127:0] r;
        int v;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            v = base + k * step;
            r[k*16 +: 16] = v[15:0];
        end
        return r;
    endfunction

    task automatic push(input logic [127:0] v);
        vec_mem[nvec] = v;
        nvec++;
    endtask

    task automatic expect_out(input int a, input logic [127:0] d);
        exp_t t;
        t.addr = a[3:0];
        t.data = d;
        sb.push_back(t);
    endtask

    task automatic start_pass(input int n, input bit fp, input bit lp);
        r0 = rd_pulses;
        d0 = done_cnt;
        o0 = ov_cnt;
        @(posedge clk); #1;
        len = n[4:0];
        first_pass = fp;
        last_pass = lp;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic finish_pass(input string nm, input int n, input bit lp);
        int k;
        k = 0;
        while (done_cnt == d0 && k < 500) begin
            @(posedge clk); #1;
            k++;
        end
        @(posedge clk); #1;
        check({nm, "_done_once"}, done_cnt - d0, 1);
        check({nm, "_rd_pulses"}, rd_pulses - r0, n);
        check({nm, "_sb_empty"}, sb.size(), 0);
        check({nm, "_idle"}, busy, 0);
        if (!lp) check({nm, "_no_out_valid"}, ov_cnt - o0, 0);
    endtask

    logic [127:0] snap_d;
    logic [3:0]   snap_a;
    logic [127:0] ramp_exp;

    initial begin
        reset = 1'b1;
        start = 1'b0;
        len = '0;
        first_pass = 1'b0;
        last_pass = 1'b0;
        out_ready = 1'b1;
        fifo_en = 1'b1;
        fifo_clr = 1'b0;
        ofifo_output = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_ofifo_rd", ofifo_rd, 0);
        check("rst_done", done, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_addr", out_addr, 0);

        // Basic pass with ReLU
        push(mk(5, 0)); push(mk(-3, 0)); push(mk(7, 0)); push(mk(0, 0));
        expect_out(0, mk(5, 0)); expect_out(1, mk(0, 0));
        expect_out(2, mk(7, 0)); expect_out(3, mk(0, 0));
        start_pass(4, 1, 1);
        finish_pass("basic", 4, 1);

        // Distinct lanes: -3000..4000
        ramp_exp = mk(0, 0);
        ramp_exp[64 +: 16]  = 16'd1000;
        ramp_exp[80 +: 16]  = 16'd2000;
        ramp_exp[96 +: 16]  = 16'd3000;
        ramp_exp[112 +: 16] = 16'd4000;
        push(mk(-3000, 1000));
        expect_out(0, ramp_exp);
        start_pass(1, 1, 1);
        finish_pass("lanes", 1, 1);

        // Accumulate across passes
        push(mk(100, 0));
        start_pass(1, 1, 0);
        finish_pass("acc_p1", 1, 0);
        push(mk(-150, 0));
        expect_out(0, mk(0, 0));
        start_pass(1, 0, 1);
        finish_pass("acc_neg", 1, 1);
        push(mk(100, 0));
        start_pass(1, 1, 0);
        finish_pass("acc_p1b", 1, 0);
        push(mk(150, 0));
        expect_out(0, mk(250, 0));
        start_pass(1, 0, 1);
        finish_pass("acc_pos", 1, 1);

        // Wrap-around, no saturation
        push(mk(32767, 0));
        start_pass(1, 1, 0);
        finish_pass("wrap_p1", 1, 0);
        push(mk(1, 0));
        start_pass(1, 0, 0);
        finish_pass("wrap_p2", 1, 0);
        push(mk(0, 0));
        expect_out(0, mk(0, 0));
        start_pass(1, 0, 1);
        finish_pass("wrap_p3", 1, 1);

        // Backpressure mid-pass
        push(mk(10, 0)); push(mk(20, 0)); push(mk(30, 0));
        expect_out(0, mk(10, 0)); expect_out(1, mk(20, 0)); expect_out(2, mk(30, 0));
        start_pass(3, 1, 1);
        for (int k = 0; k < 100 && !out_valid; k++) begin
            @(posedge clk); #1;
        end
        check("stall_saw_valid", out_valid, 1);
        out_ready = 1'b0;
        snap_d = out_data;
        snap_a = out_addr;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_valid_held", out_valid, 1);
            check("stall_data_held", out_data, snap_d);
            check("stall_addr_held", out_addr, snap_a);
            check("stall_no_rd", ofifo_rd, 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        finish_pass("stall", 3, 1);

        // Toggling ofifo_valid
        push(mk(1, 0)); push(mk(2, 0)); push(mk(3, 0));
        expect_out(0, mk(1, 0)); expect_out(1, mk(2, 0)); expect_out(2, mk(3, 0));
        start_pass(3, 1, 1);
        for (int k = 0; k < 100 && done_cnt == d0; k++) begin
            @(posedge clk); #1;
            fifo_en = ~fifo_en;
        end
        fifo_en = 1'b1;
        finish_pass("toggle", 3, 1);

        // Reset mid-DRAIN
        push(mk(9, 0)); push(mk(9, 0)); push(mk(9, 0)); push(mk(9, 0));
        expect_out(0, mk(9, 0)); expect_out(1, mk(9, 0));
        expect_out(2, mk(9, 0)); expect_out(3, mk(9, 0));
        start_pass(4, 1, 1);
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("pre_reset_busy", busy, 1);
        reset = 1'b1;
        fifo_clr = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        fifo_clr = 1'b0;
        @(negedge clk);
        check("midrst_busy", busy, 0);
        check("midrst_ofifo_rd", ofifo_rd, 0);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_data", out_data, 0);
        sb.delete();
        push(mk(6, 0));
        expect_out(0, mk(6, 0));
        start_pass(1, 1, 1);
        finish_pass("post_reset", 1, 1);

        // Zero-length pass
        start_pass(0, 1, 1);
        @(negedge clk);
        check("len0_done", done, 1);
        check("len0_busy", busy, 1);
        finish_pass("len0", 0, 1);

        // Start while busy is ignored
        fifo_en = 1'b0;
        push(mk(7, 0)); push(mk(8, 0));
        expect_out(0, mk(7, 0)); expect_out(1, mk(8, 0));
        start_pass(2, 1, 1);
        repeat (3) begin
            @(posedge clk); #1;
        end
        len = '0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("ignore_busy", busy, 1);
        check("ignore_no_done", done_cnt - d0, 0);
        check("ignore_no_rd", rd_pulses - r0, 0);
        fifo_en = 1'b1;
        finish_pass("ignore", 2, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: got no completion want completion");
        $fatal(1);
    end

endmodule
